// File: rtl/vai_pkg.sv
// vai_pkg: shared types and constants for the VAI Tx audit lane.
// The Tx port structs are a trimmed CCI-P style request bundle (c0 read,
// c1 write, c2 MMIO response) carrying only the fields this lane touches.
package vai_pkg;

  localparam int VAI_CL_ADDR_W  = 42;
  localparam int VAI_VIOL_CNT_W = 32;
  localparam int VAI_TX_DATA_W  = 64;

  typedef logic [63:0]              t_vai_offset;
  typedef logic [VAI_CL_ADDR_W-1:0] t_cl_addr;

  typedef struct packed {
    logic [3:0]  req_type;
    t_cl_addr    address;
    logic [15:0] mdata;
  } t_c0_req_hdr;

  typedef struct packed {
    logic        sop;
    logic [1:0]  cl_len;
    logic [3:0]  req_type;
    t_cl_addr    address;
    logic [15:0] mdata;
  } t_c1_req_hdr;

  typedef struct packed {
    t_c0_req_hdr hdr;
    logic        valid;
  } t_if_ccip_c0_Tx;

  typedef struct packed {
    t_c1_req_hdr              hdr;
    logic [VAI_TX_DATA_W-1:0] data;
    logic                     valid;
  } t_if_ccip_c1_Tx;

  typedef struct packed {
    logic [8:0]  tid;
    logic [63:0] data;
    logic        mmioRdValid;
  } t_if_ccip_c2_Tx;

  typedef struct packed {
    t_if_ccip_c0_Tx c0;
    t_if_ccip_c1_Tx c1;
    t_if_ccip_c2_Tx c2;
  } t_if_ccip_Tx;

endpackage

// File: rtl/vai_addr_xlate.sv
// vai_addr_xlate: one channel's offset add and window compare.
// Window compare is only built when VAI_AUDIT_BOUNDS_CHECK_EN is defined;
// otherwise oob is tied low and bound is ignored.
module vai_addr_xlate
  import vai_pkg::*;
(
  input  t_cl_addr    addr_in,
  input  t_vai_offset offset,
  input  t_vai_offset bound,
  output t_cl_addr    addr_out,
  output logic        oob
);

  // Line addresses above bit 41 do not exist on the link; the add wraps.
  logic unused_offset_hi;
  assign unused_offset_hi = ^offset[63:VAI_CL_ADDR_W];
  assign addr_out = addr_in + offset[VAI_CL_ADDR_W-1:0];

`ifdef VAI_AUDIT_BOUNDS_CHECK_EN
  // Lane-relative address is the untranslated one, zero-extended to 64 bits.
  assign oob = {{(64-VAI_CL_ADDR_W){1'b0}}, addr_in} >= bound;
`else
  logic unused_bound;
  assign unused_bound = ^bound;
  assign oob = 1'b0;
`endif

endmodule

// File: rtl/vai_tx_audit_lane.sv
// vai_tx_audit_lane: translates one sub-AFU's Tx requests into its window,
// drops out-of-window requests and counts them, squashes c0/c1 when the lane
// is disabled, and delays everything (c2 included) by PIPE_STAGES (1 or 2).
// Optional feature macro: VAI_AUDIT_BOUNDS_CHECK_EN (window audit, violation
// counter and sticky flag). Without it only translation and squash remain.
module vai_tx_audit_lane
  import vai_pkg::*;
#(
  parameter int PIPE_STAGES = 2,
  parameter int VIOL_CNT_W  = VAI_VIOL_CNT_W
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  lane_en,
  input  t_vai_offset           offset,
  input  t_vai_offset           bound,
  input  t_if_ccip_Tx           afu_TxPort,
  output t_if_ccip_Tx           up_TxPort,
  output logic [VIOL_CNT_W-1:0] viol_cnt,
  output logic                  viol_flag
);

  t_cl_addr c0_addr_x, c1_addr_x;
  logic     c0_oob, c1_oob;

  vai_addr_xlate u_xlate_c0 (
    .addr_in  (afu_TxPort.c0.hdr.address),
    .offset   (offset),
    .bound    (bound),
    .addr_out (c0_addr_x),
    .oob      (c0_oob)
  );

  vai_addr_xlate u_xlate_c1 (
    .addr_in  (afu_TxPort.c1.hdr.address),
    .offset   (offset),
    .bound    (bound),
    .addr_out (c1_addr_x),
    .oob      (c1_oob)
  );

  t_if_ccip_Tx                   pipe_d;
  t_if_ccip_Tx [PIPE_STAGES-1:0] pipe_q;
  logic                          last_keep_d, last_keep_q;
  logic                          c1_keep;

  // First stage: translate, audit and squash using this cycle's config.
  // Non-sop c1 beats reuse the keep decision of the burst's sop beat.
  always_comb begin
    pipe_d      = afu_TxPort;
    last_keep_d = last_keep_q;
    c1_keep     = last_keep_q;
    pipe_d.c0.hdr.address = c0_addr_x;
    pipe_d.c0.valid       = afu_TxPort.c0.valid & lane_en & ~c0_oob;
    if (afu_TxPort.c1.valid && afu_TxPort.c1.hdr.sop) begin
      pipe_d.c1.hdr.address = c1_addr_x;
      c1_keep               = ~c1_oob;
      last_keep_d           = ~c1_oob;
    end
    pipe_d.c1.valid = afu_TxPort.c1.valid & lane_en & c1_keep;
  end

  // Request pipeline; reset discards anything in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pipe_q      <= '0;
      last_keep_q <= 1'b0;
    end else begin
      pipe_q[0]   <= pipe_d;
      last_keep_q <= last_keep_d;
      for (int s = 1; s < PIPE_STAGES; s++) pipe_q[s] <= pipe_q[s-1];
    end
  end

  assign up_TxPort = pipe_q[PIPE_STAGES-1];

`ifdef VAI_AUDIT_BOUNDS_CHECK_EN
  localparam int CW = VIOL_CNT_W + 1;

  logic                  viol_c0, viol_c1;
  logic [VIOL_CNT_W:0]   cnt_sum;
  logic [VIOL_CNT_W-1:0] viol_cnt_d, viol_cnt_q;
  logic                  viol_flag_d, viol_flag_q;

  // Saturating violation count; squashed (lane disabled) requests are not violations.
  always_comb begin
    viol_c0     = afu_TxPort.c0.valid & lane_en & c0_oob;
    viol_c1     = afu_TxPort.c1.valid & afu_TxPort.c1.hdr.sop & lane_en & c1_oob;
    cnt_sum     = {1'b0, viol_cnt_q} + CW'(viol_c0) + CW'(viol_c1);
    viol_cnt_d  = cnt_sum[VIOL_CNT_W] ? '1 : cnt_sum[VIOL_CNT_W-1:0];
    viol_flag_d = viol_flag_q | viol_c0 | viol_c1;
  end

  // Counter and sticky flag registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      viol_cnt_q  <= '0;
      viol_flag_q <= 1'b0;
    end else begin
      viol_cnt_q  <= viol_cnt_d;
      viol_flag_q <= viol_flag_d;
    end
  end

  assign viol_cnt  = viol_cnt_q;
  assign viol_flag = viol_flag_q;
`else
  assign viol_cnt  = '0;
  assign viol_flag = 1'b0;
`endif

endmodule

// File: tb/tb_vai_tx_audit_lane.sv
// tb_vai_tx_audit_lane: directed vectors against a 2-stage / 32-bit-counter
// instance and a 1-stage / 4-bit-counter instance sharing the same inputs.
// Audit expectations follow VAI_AUDIT_BOUNDS_CHECK_EN as the build defines it.
module tb_vai_tx_audit_lane;
  import vai_pkg::*;

`ifdef VAI_AUDIT_BOUNDS_CHECK_EN
  localparam bit AUD = 1'b1;
`else
  localparam bit AUD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        lane_en;
  t_vai_offset offset, bound;
  t_if_ccip_Tx afu, up, up2;
  logic [31:0] cnt;
  logic [3:0]  cnt2;
  logic        flag, flag2;

  vai_tx_audit_lane #(.PIPE_STAGES(2), .VIOL_CNT_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .lane_en(lane_en), .offset(offset), .bound(bound),
    .afu_TxPort(afu), .up_TxPort(up), .viol_cnt(cnt), .viol_flag(flag)
  );

  vai_tx_audit_lane #(.PIPE_STAGES(1), .VIOL_CNT_W(4)) dut2 (
    .clk(clk), .reset_n(reset_n), .lane_en(lane_en), .offset(offset), .bound(bound),
    .afu_TxPort(afu), .up_TxPort(up2), .viol_cnt(cnt2), .viol_flag(flag2)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  longint exp_cnt = 0;

  t_if_ccip_Tx stim [24];
  t_if_ccip_Tx expv [24];
  t_vai_offset off_s [24];
  t_vai_offset bnd_s [24];
  logic        en_s  [24];
  t_if_ccip_Tx idle_t;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cmp_tx(input string tag, input t_if_ccip_Tx got, input t_if_ccip_Tx exp);
    chk({tag, "/c0v"}, 64'(got.c0.valid), 64'(exp.c0.valid));
    if (exp.c0.valid) begin
      chk({tag, "/c0a"}, 64'(got.c0.hdr.address), 64'(exp.c0.hdr.address));
      chk({tag, "/c0m"}, 64'(got.c0.hdr.mdata), 64'(exp.c0.hdr.mdata));
    end
    chk({tag, "/c1v"}, 64'(got.c1.valid), 64'(exp.c1.valid));
    if (exp.c1.valid) begin
      chk({tag, "/c1a"}, 64'(got.c1.hdr.address), 64'(exp.c1.hdr.address));
      chk({tag, "/c1s"}, 64'(got.c1.hdr.sop), 64'(exp.c1.hdr.sop));
      chk({tag, "/c1d"}, got.c1.data, exp.c1.data);
    end
    chk({tag, "/c2v"}, 64'(got.c2.mmioRdValid), 64'(exp.c2.mmioRdValid));
    if (exp.c2.mmioRdValid) begin
      chk({tag, "/c2t"}, 64'(got.c2.tid), 64'(exp.c2.tid));
      chk({tag, "/c2d"}, got.c2.data, exp.c2.data);
    end
  endtask

  function automatic t_if_ccip_Tx mk(input logic c0v, input logic [41:0] a0,
                                     input logic c1v, input logic sop, input logic [41:0] a1);
    t_if_ccip_Tx t;
    t = '0;
    t.c0.valid         = c0v;
    t.c0.hdr.address   = a0;
    t.c0.hdr.mdata     = 16'hC0DE ^ a0[15:0];
    t.c1.valid         = c1v;
    t.c1.hdr.sop       = sop;
    t.c1.hdr.address   = a1;
    t.c1.hdr.mdata     = 16'hC1DE;
    t.c1.data          = {22'h0, a1} ^ 64'h0123_4567_89AB_CDEF;
    return t;
  endfunction

  // Expected output: the stimulus with hand-computed addresses and valids.
  function automatic t_if_ccip_Tx xp(input t_if_ccip_Tx s, input logic c0v, input logic [41:0] a0,
                                     input logic c1v, input logic [41:0] a1);
    t_if_ccip_Tx t;
    t = s;
    t.c0.valid       = c0v;
    t.c0.hdr.address = a0;
    t.c1.valid       = c1v;
    t.c1.hdr.address = a1;
    return t;
  endfunction

  task automatic cfg_all(input t_vai_offset o, input t_vai_offset b, input logic e);
    for (int i = 0; i < 24; i++) begin
      off_s[i] = o;
      bnd_s[i] = b;
      en_s[i]  = e;
    end
  endtask

  // Feed n back-to-back cycles; the 1-stage instance shows beat i after one
  // edge, the 2-stage instance one edge later, with nothing before or after.
  task automatic run_stream(input string tag, input int n);
    for (int i = 0; i <= n; i++) begin
      if (i < n) begin
        afu = stim[i]; offset = off_s[i]; bound = bnd_s[i]; lane_en = en_s[i];
      end else begin
        afu = '0;
      end
      step();
      cmp_tx({tag, "/p1"}, up2, (i < n) ? expv[i] : idle_t);
      cmp_tx({tag, "/p2"}, up, (i > 0) ? expv[i-1] : idle_t);
    end
    step();
    cmp_tx({tag, "/p2end"}, up, idle_t);
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, "/cnt"}, 64'(cnt), 64'(exp_cnt));
    chk({tag, "/cnt4"}, 64'(cnt2), (exp_cnt > 15) ? 64'd15 : 64'(exp_cnt));
    chk({tag, "/flag"}, 64'(flag), 64'(exp_cnt != 0));
  endtask

  initial begin
    idle_t  = '0;
    reset_n = 1'b0;
    lane_en = 1'b1;
    offset  = 64'h1000;
    bound   = 64'h100;
    afu     = mk(1'b1, 42'h20, 1'b1, 1'b1, 42'h30);
    afu.c2.mmioRdValid = 1'b1;
    step();
    step();
    // Reset state with valid traffic presented
    chk("rst/up_c0v", 64'(up.c0.valid), 64'd0);
    chk("rst/up_c1v", 64'(up.c1.valid), 64'd0);
    chk("rst/up_c2v", 64'(up.c2.mmioRdValid), 64'd0);
    chk("rst/up2_c0v", 64'(up2.c0.valid), 64'd0);
    chk_cnt("rst");
    afu = '0;
    reset_n = 1'b1;
    step();

    // Non-sop beat right after reset inherits "drop"
    cfg_all(64'h1000, 64'h100, 1'b1);
    stim[0] = mk(1'b0, 42'h0, 1'b1, 1'b0, 42'h5);
    expv[0] = xp(stim[0], 1'b0, 42'h0, 1'b0, 42'h5);
    run_stream("orphan", 1);

    // Basic read translation
    stim[0] = mk(1'b1, 42'h20, 1'b0, 1'b0, 42'h0);
    expv[0] = xp(stim[0], 1'b1, 42'h1020, 1'b0, 42'h0);
    run_stream("rd", 1);
    chk_cnt("rd");

    // Translation wraps modulo 2^42
    cfg_all(64'hFFFF_FFFF_FFFF_FFF0, 64'h100, 1'b1);
    stim[0] = mk(1'b1, 42'h20, 1'b1, 1'b1, 42'h30);
    expv[0] = xp(stim[0], 1'b1, 42'h10, 1'b1, 42'h20);
    run_stream("wrap", 1);

    // 4-beat write, sop at bound-1: all pass, only sop address shifted
    cfg_all(64'h1000, 64'h100, 1'b1);
    stim[0] = mk(1'b0, 42'h0, 1'b1, 1'b1, 42'hFF);
    stim[1] = mk(1'b0, 42'h0, 1'b1, 1'b0, 42'h1);
    stim[2] = mk(1'b0, 42'h0, 1'b1, 1'b0, 42'h2);
    stim[3] = mk(1'b0, 42'h0, 1'b1, 1'b0, 42'h3);
    expv[0] = xp(stim[0], 1'b0, 42'h0, 1'b1, 42'h10FF);
    expv[1] = xp(stim[1], 1'b0, 42'h0, 1'b1, 42'h1);
    expv[2] = xp(stim[2], 1'b0, 42'h0, 1'b1, 42'h2);
    expv[3] = xp(stim[3], 1'b0, 42'h0, 1'b1, 42'h3);
    run_stream("wr_in", 4);
    chk_cnt("wr_in");

    // Same burst with sop at bound: whole burst dropped, one violation
    stim[0] = mk(1'b0, 42'h0, 1'b1, 1'b1, 42'h100);
    expv[0] = xp(stim[0], 1'b0, 42'h0, !AUD, 42'h1100);
    for (int i = 1; i < 4; i++) expv[i].c1.valid = !AUD;
    run_stream("wr_oob", 4);
    exp_cnt += AUD ? 1 : 0;
    chk_cnt("wr_oob");

    // c0 and c1 violations in one cycle count two
    stim[0] = mk(1'b1, 42'h100, 1'b1, 1'b1, 42'h200);
    expv[0] = xp(stim[0], !AUD, 42'h1100, !AUD, 42'h1200);
    run_stream("dual", 1);
    exp_cnt += AUD ? 2 : 0;
    chk_cnt("dual");

    // Config changes take effect per accepted request
    stim[0] = mk(1'b1, 42'h10, 1'b0, 1'b0, 42'h0);
    stim[1] = mk(1'b1, 42'h10, 1'b0, 1'b0, 42'h0);
    stim[2] = mk(1'b1, 42'h80, 1'b0, 1'b0, 42'h0);
    stim[3] = mk(1'b1, 42'h80, 1'b0, 1'b0, 42'h0);
    off_s[1] = 64'h2000; off_s[2] = 64'h2000; off_s[3] = 64'h2000;
    bnd_s[2] = 64'h80;   bnd_s[3] = 64'h81;
    expv[0] = xp(stim[0], 1'b1, 42'h1010, 1'b0, 42'h0);
    expv[1] = xp(stim[1], 1'b1, 42'h2010, 1'b0, 42'h0);
    expv[2] = xp(stim[2], !AUD, 42'h2080, 1'b0, 42'h0);
    expv[3] = xp(stim[3], 1'b1, 42'h2080, 1'b0, 42'h0);
    run_stream("cfg", 4);
    exp_cnt += AUD ? 1 : 0;
    chk_cnt("cfg");

    // Lane disabled: only the MMIO response goes out, no violation counted
    cfg_all(64'h1000, 64'h100, 1'b1);
    stim[0] = mk(1'b1, 42'h400, 1'b1, 1'b1, 42'h30);
    stim[0].c2.mmioRdValid = 1'b1;
    stim[0].c2.tid         = 9'h1A5;
    stim[0].c2.data        = 64'hDEAD_BEEF_0123_4567;
    en_s[0] = 1'b0;
    stim[1] = mk(1'b1, 42'h21, 1'b0, 1'b0, 42'h0);
    expv[0] = xp(stim[0], 1'b0, 42'h1400, 1'b0, 42'h1030);
    expv[1] = xp(stim[1], 1'b1, 42'h1021, 1'b0, 42'h0);
    run_stream("dis", 2);
    chk_cnt("dis");

    // Empty window
    cfg_all(64'h1000, 64'h0, 1'b1);
    stim[0] = mk(1'b1, 42'h0, 1'b1, 1'b1, 42'h0);
    expv[0] = xp(stim[0], !AUD, 42'h1000, !AUD, 42'h1000);
    run_stream("bnd0", 1);
    exp_cnt += AUD ? 2 : 0;
    chk_cnt("bnd0");

    // 20 back-to-back violations: narrow counter saturates
    cfg_all(64'h1000, 64'h100, 1'b1);
    for (int i = 0; i < 20; i++) begin
      stim[i] = mk(1'b1, 42'h300, 1'b0, 1'b0, 42'h0);
      expv[i] = xp(stim[i], !AUD, 42'h1300, 1'b0, 42'h0);
    end
    run_stream("sat", 20);
    exp_cnt += AUD ? 20 : 0;
    chk_cnt("sat");

    // Reset mid-burst: in-flight requests vanish, counters clear
    lane_en = 1'b1; offset = 64'h1000; bound = 64'h100;
    afu = mk(1'b1, 42'h40, 1'b0, 1'b0, 42'h0);
    step();
    step();
    chk("mid/pre_c0v", 64'(up.c0.valid), 64'd1);
    reset_n = 1'b0;
    #1;
    exp_cnt = 0;
    chk("mid/up_c0v", 64'(up.c0.valid), 64'd0);
    chk("mid/up2_c0v", 64'(up2.c0.valid), 64'd0);
    chk_cnt("mid");
    step();
    afu = '0;
    reset_n = 1'b1;
    step();
    chk("post/up_c0v", 64'(up.c0.valid), 64'd0);
    chk("post/up2_c0v", 64'(up2.c0.valid), 64'd0);
    step();
    chk("post2/up_c0v", 64'(up.c0.valid), 64'd0);
    chk_cnt("post");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/vai_tx_audit_lane.md
VAI_TX_AUDIT_LANE -- requirements
Module: vai_tx_audit_lane

Interface
REQ-001 SHALL take parameter PIPE_STAGES, default 2, allowed 1 or 2: register stages between afu_TxPort and up_TxPort.
REQ-002 SHALL take parameter VIOL_CNT_W, default 32: violation counter width.
REQ-003 clk  input  1  sole clock; every register is clocked on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 lane_en  input  1  sub-AFU enable from vai_mgr_afu; low means every request is squashed.
REQ-006 offset  input  64  base line-address offset for this sub-AFU.
REQ-007 bound  input  64  window size in cache lines; legal lane-relative addresses are 0..bound-1.
REQ-008 afu_TxPort  input  t_if_ccip_Tx  Tx requests from one sub-AFU.
REQ-009 up_TxPort  output  t_if_ccip_Tx  translated and audited Tx toward the Tx mux.
REQ-010 viol_cnt  output  VIOL_CNT_W  count of dropped out-of-window requests.
REQ-011 viol_flag  output  1  sticky flag: at least one violation since reset.

Function
REQ-012 Latency SHALL be exactly PIPE_STAGES cycles on c0, c1 and c2, with no bubbles and no reordering.
REQ-013 c0 read requests SHALL leave with address = input address + offset[41:0], truncated modulo 2^42.
REQ-014 Each c1 write request whose sop bit is set SHALL be translated the same way as c0.
REQ-015 For a c1 beat with sop clear, the address field SHALL pass unchanged, and the beat SHALL inherit the keep/drop decision of the last sop beat.
REQ-016 A request SHALL be a violation when its lane-relative address (the input address, zero-extended to 64 bits) is >= bound; the compare is unsigned.
REQ-017 A violating request SHALL leave with its valid bit cleared; all other fields are don't-care.
REQ-018 c2 MMIO responses SHALL pass through unmodified, delayed by PIPE_STAGES, and are never audited.
REQ-019 When lane_en=0, c0 and c1 valid bits SHALL be squashed without counting a violation; c2 still passes.
REQ-020 offset, bound and lane_en SHALL be sampled in the first stage, together with the request they apply to. A change mid-stream affects only requests accepted after the change.
REQ-021 viol_cnt SHALL increment by the number of violations in a cycle (0, 1 or 2; a c0 and a c1 violation in the same cycle add 2).
REQ-022 viol_cnt SHALL saturate at all-ones and never wrap.
REQ-023 viol_flag SHALL be set on the first violation and clear only on reset.
REQ-024 The block SHALL exert no backpressure. Almost-full handling stays with the downstream mux.
REQ-025 bound=0 SHALL make every c0 request and every c1 sop request a violation.

Reset
REQ-026 While reset_n=0, all up_TxPort valid bits SHALL be 0, viol_cnt 0, viol_flag 0, and the inherited c1 decision "drop".
REQ-027 Requests in flight when reset asserts SHALL be discarded; nothing is emitted until PIPE_STAGES cycles after valid input following deassertion.

Configuration
REQ-028 Macro VAI_AUDIT_BOUNDS_CHECK_EN.
  - Defined: REQ-016 through REQ-023 and REQ-025 apply.
  - Undefined: only offset translation and the lane_en squash apply; viol_cnt is tied 0, viol_flag is tied 0, and no compare logic is built.

Structure
REQ-029 Package vai_pkg SHALL hold the t_vai_offset typedef (64-bit), the VAI_CL_ADDR_W=42 constant and the VAI_VIOL_CNT_W default.
REQ-030 Sub-module vai_addr_xlate SHALL implement one channel's add-and-compare stage. It is instantiated once for c0 and once for c1.

Verification
REQ-031 offset=0x1000, bound=0x100, lane_en=1; c0 read at addr 0x20 -> 2 cycles later up c0 valid, addr 0x1020, viol_cnt=0.
REQ-032 Same config; c0 read at addr 0x100 and c1 sop write at 0x200 in one cycle -> both up valids 0, viol_cnt=2, viol_flag=1.
REQ-033 c1 4-beat write with sop beat at addr 0xFF, bound=0x100 -> all 4 beats emitted and only the sop beat's address shifted. Repeat with sop beat at 0x100 -> all 4 beats dropped, viol_cnt +1.
REQ-034 lane_en=0; c0 and c1 requests plus a c2 MMIO response -> only c2 emitted, 2 cycles later, and viol_cnt unchanged.
REQ-035 VIOL_CNT_W=4, 20 single violations -> viol_cnt holds 0xF. Pulse reset_n low mid-burst -> viol_cnt=0, viol_flag=0, no valid output the next cycle.
REQ-036 Build without VAI_AUDIT_BOUNDS_CHECK_EN, bound=0 -> all requests pass translated and viol_cnt stays 0.
